// File: rtl/lzss_decoder_pkg.sv
// rtl/lzss_decoder_pkg.sv - shared sizes, token layout and FSM state type for the LZSS decoder.
package lzss_decoder_pkg;
  localparam int SEARCH_BUFFER_DEPTH     = 7;
  localparam int SEARCH_BUFFER_WIDTH     = 8;
  localparam int HIST_DEPTH              = SEARCH_BUFFER_DEPTH * SEARCH_BUFFER_WIDTH;
  localparam int LOOKAHEAD_BUFFER_LENGTH = 8;
  localparam int MIN_MATCH               = 4;

  localparam int LZSS_TOKEN_W = 24;
  localparam int LEN_MSB      = 23;
  localparam int LEN_LSB      = 16;
  localparam int OFF_MSB      = 15;
  localparam int OFF_LSB      = 0;

  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  // Read index is wr_ptr - off, which needs one sign bit beyond PTR_W.
  localparam int IDX_W  = 7;

  typedef struct packed {
    logic [7:0]  length;
    logic [15:0] offset;
  } lzss_match_t;

  typedef enum logic {
    ST_IDLE,
    ST_COPY
  } lzss_state_e;
endpackage

// File: rtl/lzss_decoder_if.sv
// rtl/lzss_decoder_if.sv - token-in / symbol-out handshake bundle for the LZSS decoder.
interface lzss_decoder_if;
  import lzss_decoder_pkg::*;

  logic [LZSS_TOKEN_W-1:0] token_in;
  logic                    literal;
  logic                    token_valid;
  logic                    token_ready;
  logic [7:0]              data_out;
  logic                    data_valid;
  logic                    data_ready;
  logic                    busy;
  logic                    err;

  modport master (
    output token_in, literal, token_valid, data_ready,
    input  token_ready, data_out, data_valid, busy, err
  );

  modport slave (
    input  token_in, literal, token_valid, data_ready,
    output token_ready, data_out, data_valid, busy, err
  );
endinterface

// File: rtl/lzss_decoder_history_buffer.sv
// rtl/lzss_decoder_history_buffer.sv - circular history of emitted symbols with fill count
// and combinational back-reference read at (wr_ptr - off) mod HIST_DEPTH.
module lzss_history_buffer
  import lzss_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              we_i,
  input  logic [7:0]        wdata_i,
  input  logic [IDX_W-1:0]  off_i,
  output logic [7:0]        rdata_o,
  output logic [FILL_W-1:0] fill_o
);
  logic [7:0]        mem_q [HIST_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  diff, rd_idx;

  // Depth is not a power of two, so a negative difference is folded by adding HIST_DEPTH.
  always_comb begin
    diff    = IDX_W'(wr_ptr_q) - off_i;
    rd_idx  = diff[IDX_W-1] ? diff + IDX_W'(HIST_DEPTH) : diff;
    rdata_o = (rd_idx < IDX_W'(HIST_DEPTH)) ? mem_q[rd_idx[PTR_W-1:0]] : 8'h00;
    wr_ptr_d = (wr_ptr_q == PTR_W'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    fill_d   = (fill_q == FILL_W'(HIST_DEPTH)) ? fill_q : fill_q + 1'b1;
  end

  assign fill_o = fill_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (we_i) begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/lzss_decoder.sv
// rtl/lzss_decoder.sv - LZSS token decoder: literal pass-through, match expansion from
// history one symbol per cycle, legality check with error pulse for dropped tokens.
module lzss_decoder
  import lzss_decoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  lzss_decoder_if.slave  bus
);
  lzss_state_e       state_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;
  logic [IDX_W-1:0]  off_q;
  logic [7:0]        rem_q;

  lzss_match_t       tok_m;
  logic              out_free;
  logic              accept;
  logic              legal;
  logic              hist_we;
  logic [7:0]        hist_wdata;
  logic [7:0]        hist_rdata;
  logic [IDX_W-1:0]  rd_off;
  logic [FILL_W-1:0] fill;

  always_comb begin
    tok_m    = lzss_match_t'(bus.token_in[LEN_MSB:OFF_LSB]);
    out_free = !valid_q || bus.data_ready;
    accept   = bus.token_valid && bus.token_ready;
    legal    = (tok_m.length >= 8'(MIN_MATCH)) &&
               (tok_m.length <= 8'(LOOKAHEAD_BUFFER_LENGTH)) &&
               (tok_m.offset != 16'd0) &&
               (tok_m.offset <= 16'(fill));
    // In IDLE the first match symbol is read with the incoming offset, before it is latched.
    rd_off     = (state_q == ST_COPY) ? off_q : tok_m.offset[IDX_W-1:0];
    hist_we    = !rst_ &&
                 (((state_q == ST_IDLE) && accept && (bus.literal || legal)) ||
                  ((state_q == ST_COPY) && out_free));
    hist_wdata = ((state_q == ST_IDLE) && bus.literal) ? bus.token_in[7:0] : hist_rdata;
  end

  assign bus.token_ready = !rst_ && (state_q == ST_IDLE) && out_free;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

  lzss_history_buffer u_hist (
    .clk     (clk),
    .rst_    (rst_),
    .we_i    (hist_we),
    .wdata_i (hist_wdata),
    .off_i   (rd_off),
    .rdata_o (hist_rdata),
    .fill_o  (fill)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      rem_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.data_ready) valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.literal) begin
              data_q  <= bus.token_in[7:0];
              valid_q <= 1'b1;
            end else if (legal) begin
              data_q  <= hist_rdata;
              valid_q <= 1'b1;
              off_q   <= tok_m.offset[IDX_W-1:0];
              rem_q   <= tok_m.length - 8'd1;
              state_q <= ST_COPY;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_COPY: begin
          if (out_free) begin
            data_q  <= hist_rdata;
            valid_q <= 1'b1;
            rem_q   <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lzss_decoder.sv
// tb/tb_lzss_decoder.sv - directed table-driven bench for the LZSS decoder.
module tb_lzss_decoder;
  import lzss_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  lzss_decoder_if bus ();

  lzss_decoder dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    logic        lit;
    logic [23:0] tok;
    int          n_out;
    logic [63:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t       vec[$];
  int         g_lo[6];
  int         g_hi[6];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] out_q[$];
  int         err_seen, busy_cyc, nrdy_cyc, first_acc, first_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk_lit(input logic [7:0] s);
    vec_t v;
    v.lit = 1'b1; v.tok = {16'hA5A5, s}; v.n_out = 1; v.exp = {56'h0, s}; v.exp_err = 1'b0;
    return v;
  endfunction

  function automatic vec_t mk_mat(input logic [7:0] len, input logic [15:0] off,
                                  input int n, input logic [63:0] e, input logic er);
    vec_t v;
    v.lit = 1'b0; v.tok = {len, off}; v.n_out = n; v.exp = e; v.exp_err = er;
    return v;
  endfunction

  task automatic do_reset(input bit check);
    rst_ = 1'b1;
    bus.token_valid = 1'b0;
    bus.literal     = 1'b0;
    bus.token_in    = '0;
    bus.data_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_token_ready", bus.token_ready, 0);
      chk("rst_data_valid",  bus.data_valid, 0);
      chk("rst_data_out",    bus.data_out, 0);
      chk("rst_busy",        bus.busy, 0);
      chk("rst_err",         bus.err, 0);
    end
    rst_ = 1'b0;
  endtask

  task automatic run(input int lo, input int hi, input logic [31:0] rdy_mask);
    int idx, cyc, idle;
    logic pv, pr;
    logic [7:0] pd;
    idx = lo; cyc = 0; idle = 0; pv = 1'b0; pr = 1'b1; pd = '0;
    out_q.delete();
    err_seen = 0; busy_cyc = 0; nrdy_cyc = 0; first_acc = -1; first_out = -1;
    while (cyc < 400 && idle < 3) begin
      @(posedge clk);
      #1;
      if (pv && !pr) begin
        chk("hold_valid", bus.data_valid, 1);
        chk("hold_data", bus.data_out, pd);
      end
      bus.data_ready = (cyc < 32) ? rdy_mask[cyc] : 1'b1;
      if (idx < hi) begin
        bus.token_valid = 1'b1;
        bus.literal     = vec[idx].lit;
        bus.token_in    = vec[idx].tok;
      end else begin
        bus.token_valid = 1'b0;
      end
      #1;
      if (bus.err) err_seen++;
      if (bus.busy) busy_cyc++;
      if (!bus.token_ready) nrdy_cyc++;
      if (bus.data_valid && bus.data_ready) begin
        out_q.push_back(bus.data_out);
        if (first_out < 0) first_out = cyc;
      end
      if (bus.token_valid && bus.token_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      pv = bus.data_valid; pr = bus.data_ready; pd = bus.data_out;
      if (idx >= hi && !bus.busy && !bus.data_valid) idle++;
      else idle = 0;
      cyc++;
    end
    bus.token_valid = 1'b0;
    chk("all_tokens_accepted", idx, hi);
  endtask

  task automatic check_group(input string nm, input int lo, input int hi);
    logic [7:0] exp_q[$];
    int exp_err;
    exp_err = 0;
    for (int i = lo; i < hi; i++) begin
      for (int j = 0; j < vec[i].n_out; j++) exp_q.push_back(vec[i].exp[8*j +: 8]);
      if (vec[i].exp_err) exp_err++;
    end
    chk({nm, "_count"}, out_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
      chk($sformatf("%s_data%0d", nm, k), out_q[k], exp_q[k]);
    chk({nm, "_err"}, err_seen, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    g_lo[0] = vec.size();
    vec.push_back(mk_lit(8'h41)); vec.push_back(mk_lit(8'h42)); vec.push_back(mk_lit(8'h43));
    g_hi[0] = vec.size();

    g_lo[1] = vec.size();
    for (int i = 0; i < 4; i++) vec.push_back(mk_lit(8'h41 + 8'(i)));
    vec.push_back(mk_mat(8'd4, 16'd4, 4, 64'h0000_0000_4443_4241, 1'b0));
    g_hi[1] = vec.size();

    g_lo[2] = vec.size();
    vec.push_back(mk_lit(8'h61));
    vec.push_back(mk_mat(8'd8, 16'd1, 8, 64'h6161_6161_6161_6161, 1'b0));
    g_hi[2] = vec.size();

    g_lo[3] = vec.size();
    for (int i = 0; i < 60; i++) vec.push_back(mk_lit(8'(i)));
    vec.push_back(mk_mat(8'd5, 16'd56, 5, 64'h0000_0008_0706_0504, 1'b0));
    g_hi[3] = vec.size();

    g_lo[4] = vec.size();
    for (int i = 1; i <= 6; i++) vec.push_back(mk_lit(8'(i * 8'h11)));
    vec.push_back(mk_mat(8'd6, 16'd6, 6, 64'h0000_6655_4433_2211, 1'b0));
    g_hi[4] = vec.size();

    g_lo[5] = vec.size();
    vec.push_back(mk_lit(8'h01)); vec.push_back(mk_lit(8'h02));
    vec.push_back(mk_mat(8'd3, 16'd1,  0, 64'h0, 1'b1));
    vec.push_back(mk_mat(8'd9, 16'd1,  0, 64'h0, 1'b1));
    vec.push_back(mk_mat(8'd4, 16'd0,  0, 64'h0, 1'b1));
    vec.push_back(mk_mat(8'd4, 16'd10, 0, 64'h0, 1'b1));
    vec.push_back(mk_lit(8'h5A));
    g_hi[5] = vec.size();

    do_reset(1'b1);
    run(g_lo[0], g_hi[0], 32'hFFFF_FFFF);
    check_group("literals", g_lo[0], g_hi[0]);
    chk("first_symbol_latency", first_out, first_acc + 1);

    do_reset(1'b0);
    run(g_lo[1], g_hi[1], 32'hFFFF_FFFF);
    check_group("match4", g_lo[1], g_hi[1]);
    chk("match4_busy_cycles", busy_cyc, 3);
    chk("match4_not_ready_cycles", nrdy_cyc, 3);

    do_reset(1'b0);
    run(g_lo[2], g_hi[2], 32'hFFFF_FFFF);
    check_group("overlap", g_lo[2], g_hi[2]);
    chk("overlap_busy_cycles", busy_cyc, 7);

    do_reset(1'b0);
    run(g_lo[3], g_hi[3], 32'hFFFF_FFFF);
    check_group("wrap", g_lo[3], g_hi[3]);

    do_reset(1'b0);
    run(g_lo[4], g_hi[4], ~32'h0000_0300);
    check_group("backpressure", g_lo[4], g_hi[4]);

    do_reset(1'b0);
    run(g_lo[5], g_hi[5], 32'hFFFF_FFFF);
    check_group("illegal", g_lo[5], g_hi[5]);

    // Reset during an expansion, then an offset into now-stale history must be rejected.
    do_reset(1'b0);
    @(posedge clk); #1;
    bus.data_ready  = 1'b1;
    bus.token_valid = 1'b1;
    bus.literal     = 1'b1;
    bus.token_in    = 24'h000077;
    @(posedge clk); #1;
    bus.literal  = 1'b0;
    bus.token_in = {8'd8, 16'd1};
    @(posedge clk); #1;
    bus.token_valid = 1'b0;
    chk("midcopy_busy", bus.busy, 1);
    chk("midcopy_data", bus.data_out, 8'h77);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;
    chk("midcopy_rst_valid", bus.data_valid, 0);
    chk("midcopy_rst_busy", bus.busy, 0);
    chk("midcopy_rst_token_ready", bus.token_ready, 0);
    rst_ = 1'b0;
    #1;
    chk("post_rst_token_ready", bus.token_ready, 1);
    bus.token_valid = 1'b1;
    bus.literal     = 1'b0;
    bus.token_in    = {8'd4, 16'd1};
    @(posedge clk); #1;
    bus.token_valid = 1'b0;
    chk("stale_offset_err", bus.err, 1);
    chk("stale_offset_no_data", bus.data_valid, 0);
    @(posedge clk); #1;
    chk("err_single_pulse", bus.err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lzss_decoder.md
Name: lzss_decoder

Overview:
- Decompressor mate of the LZSS encoder. Consumes the encoder's 24-bit token stream plus literal flag and reconstructs the original 8-bit symbol stream.
- Keeps a circular history of the last HIST_DEPTH output symbols and expands each {length, offset} match by copying symbols from that history, one per cycle.
- Sits between the token source (encoder output, or a FIFO/channel in loopback test) and the byte sink.

Parameters:
- SEARCH_BUFFER_DEPTH, 7, rows of the encoder search window.
- SEARCH_BUFFER_WIDTH, 8, symbols per row.
- HIST_DEPTH, SEARCH_BUFFER_DEPTH*SEARCH_BUFFER_WIDTH (56), history entries; need not be a power of 2.
- LOOKAHEAD_BUFFER_LENGTH, 8, maximum legal match length.
- MIN_MATCH, 4, minimum legal match length.

Ports:
- clk  in  1  clock
- rst_  in  1  reset (synchronous, active-high)
- token_in  in  24  literal: [7:0] = symbol, [23:8] ignored; match: [23:16] = length, [15:0] = offset
- literal  in  1  1 = literal token, 0 = match token
- token_valid  in  1  token_in/literal valid
- token_ready  out  1  decoder accepts the token this cycle
- data_out  out  8  decoded symbol
- data_valid  out  1  data_out valid
- data_ready  in  1  sink accepts data_out
- busy  out  1  match expansion in progress
- err  out  1  one-cycle pulse: malformed token dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: token_ready=0, data_out=0, data_valid=0, busy=0, err=0. Also cleared: wr_ptr=0, fill=0, state=IDLE. History contents are not cleared.
- Handshakes:
  - Token transfer occurs when token_valid && token_ready.
  - Output transfer occurs when data_valid && data_ready.
  - data_out is held stable while data_valid && !data_ready.
- out_free = !data_valid || data_ready.
- FSM states: IDLE, COPY.
- IDLE:
  - token_ready = out_free.
  - Literal accepted: next cycle data_out = token_in[7:0], data_valid=1. Symbol is written to hist[wr_ptr]. wr_ptr advances; fill increments, saturating at HIST_DEPTH. State stays IDLE.
  - Match accepted and legal: latch off = offset. First copied symbol hist[(wr_ptr-off) mod HIST_DEPTH] goes to data_out next cycle and is written to history. remaining = length-1. Go to COPY.
- COPY:
  - token_ready=0 and busy=1.
  - Each cycle with out_free: output hist[(wr_ptr-off) mod HIST_DEPTH], write it to history, advance wr_ptr, decrement remaining.
  - When remaining reaches 0, return to IDLE. A new token may then be accepted that same cycle if out_free.
  - If !out_free, hold all state.
- Offset semantics: offset 1 = most recently emitted symbol.
- Overlapping copies (off < length) must replicate the pattern. The read index uses the updated wr_ptr each cycle, so newly written symbols are re-read.
- Latency and throughput:
  - Token accept at cycle N gives the first symbol valid at N+1.
  - A match of length L yields L symbols on consecutive cycles when data_ready is held high, with no bubble between tokens.
- Wrap-around: wr_ptr wraps HIST_DEPTH-1 -> 0. Read index = wr_ptr - off, plus HIST_DEPTH if negative. Compute it at 7 bits wide; no power-of-2 masking.
- Legal match: MIN_MATCH <= length <= LOOKAHEAD_BUFFER_LENGTH, and 1 <= offset <= min(fill, HIST_DEPTH).
- Illegal match: token is accepted and dropped. err pulses 1 cycle later. No symbol is output, no history write occurs, state stays IDLE.
- Reset mid-COPY aborts the expansion. The output register is invalidated the next cycle; fill=0, so offsets into stale history are illegal.
- Tokens never arrive with token_ready=0 unless the source holds them (standard valid-hold).

Decomposition:
- Package Parameters:
  - LZSS_TOKEN_W=24, LEN_MSB=23, LEN_LSB=16, OFF_MSB=15, OFF_LSB=0.
  - MIN_MATCH.
  - typedef struct packed {logic [7:0] length; logic [15:0] offset;} lzss_match_t.
  - typedef enum for IDLE/COPY.
- Sub-module lzss_history_buffer: HIST_DEPTH x 8 register array with wrapping write pointer, fill counter and combinational read at (wr_ptr-off) mod HIST_DEPTH. The FSM, handshake and legality checks stay in lzss_decoder.

Test Plan:
- Literals 0x41,0x42,0x43, token_valid every cycle, data_ready=1 -> data_out 41,42,43 on cycles N+1..N+3; err never asserted.
- Literals A,B,C,D, then match {len=4, off=4} -> output A,B,C,D,A,B,C,D; token_ready=0 for 3 cycles during COPY; busy=1 for those cycles.
- Literal 0x61, then match {len=8, off=1} -> nine consecutive 0x61 (overlap copy).
- Emit 60 literals 0..59, then match {len=5, off=56} -> outputs 4,5,6,7,8 (wrap across index 55->0).
- Backpressure: data_ready toggled 1,0,0,1 during a len=6 copy -> data_out held stable while stalled; all 6 symbols delivered in order; no duplicates.
- Illegal tokens: {len=3, off=1}, {len=9, off=1}, {len=4, off=0}, and {len=4, off=10} with fill=2 -> each gives an err pulse; no data_valid; the next literal decodes correctly. Reset asserted mid-copy -> data_valid=0 and busy=0 after the next edge.
